lsu_subword: RTL and testbench

//  Load/store unit between the CPU execute stage and the word-only data memory (sync write, async read).

---
 rtl/lsu_subword.sv | 186 ++++++++++++++++++
 tb/tb_lsu_subword.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// Load/store unit adding byte/half/word loads with extension and sub-word stores via read-modify-write
// over a word-only memory. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module lsu_subword #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [2:0] {S_IDLE, S_LD, S_RMW_RD, S_WR, S_RESP} state_t;

    state_t      state_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [1:0]  off_r;
    logic [31:0] wdata_r;

    logic        is_word_s;
    logic        misalign_s;
    logic        trap_s;
    logic [1:0]  off_s;
    logic        unused_s;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Classify the incoming request: alignment check and the lane offset actually used.
    always_comb begin
        is_word_s  = req_size[1];
        misalign_s = 1'b0;
        off_s      = req_addr[1:0];
        if (is_word_s) begin
            misalign_s = (req_addr[1:0] != 2'b00);
            off_s      = 2'b00;
        end else if (req_size == 2'b01) begin
            misalign_s = req_addr[0];
            off_s      = {req_addr[1], 1'b0};
        end else begin
            misalign_s = 1'b0;
            off_s      = req_addr[1:0];
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s   = misalign_s;
    assign unused_s = ^req_addr[31:ADDR_W+2];
`else
    assign trap_s   = 1'b0;
    assign unused_s = ^{req_addr[31:ADDR_W+2], misalign_s};
`endif

    // Transaction FSM; all CPU- and memory-side outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_din    <= 32'h0000_0000;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            off_r     <= 2'b00;
            wdata_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        size_r    <= req_size;
                        uns_r     <= req_unsigned;
                        off_r     <= off_s;
                        wdata_r   <= req_wdata;
                        dm_addr   <= req_addr[ADDR_W+1:2];
                        if (trap_s) begin
                            state_r   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else if (!req_we) begin
                            state_r <= S_LD;
                        end else if (is_word_s) begin
                            // Whole-word store needs no read: write straight away.
                            state_r <= S_WR;
                            dm_we   <= 1'b1;
                            dm_din  <= req_wdata;
                        end else begin
                            state_r <= S_RMW_RD;
                        end
                    end
                end
                S_LD: begin
                    rsp_rdata <= load_extend(dm_dout, size_r, off_r, uns_r);
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_r   <= S_RESP;
                end
                S_RMW_RD: begin
                    dm_din  <= store_merge(dm_dout, wdata_r, size_r, off_r);
                    dm_we   <= 1'b1;
                    state_r <= S_WR;
                end
                S_WR: begin
                    dm_we     <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_r   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    dm_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Scoreboard bench for lsu_subword: a behavioural word memory, directed requests, and a response monitor
// that checks data, error flag and latency of every response handshake.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_we, req_unsigned;
    logic        rsp_valid, rsp_ready, rsp_err, dm_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;
    logic [31:0] mem [0:1023];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
        logic [31:0] acc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int          we_cnt = 0;
    logic [9:0]  we_addr = 10'd0;
    logic [31:0] we_din = 32'd0;
    logic        prev_valid = 1'b0;
    int          first_c = 0;
    int          we0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: synchronous write, combinational read.
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;

    lsu_subword #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: memory-write observer and response scoreboard.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (rsp_valid && !prev_valid) first_c = cyc;
        prev_valid = rsp_valid;
        if (dm_we) begin
            we_cnt++;
            we_addr = dm_addr;
            we_din  = dm_din;
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_rdata"}, rsp_rdata, e.rdata);
                check({n, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                check({n, "_lat"}, first_c - e.acc + 1, {24'd0, e.lat});
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int lat);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        e.rdata = er; e.err = ee; e.lat = lat[7:0]; e.acc = cyc;
        exp_q.push_back(e);
        name_q.push_back(name);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && exp_q.size() == 0) && n < 200);
        if (!(req_ready && exp_q.size() == 0)) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic txn(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat);
        do_req(name, we, size, uns, addr, wd, er, ee, lat);
        wait_done(name);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_addr", {22'd0, dm_addr}, 32'd0);
        check("rst_dm_din", dm_din, 32'd0);
        rst_n = 1'b1;

        // 1: word store then word load
        we0 = we_cnt;
        txn("t1_sw", 1'b1, 2'b10, 1'b0, 32'h010, 32'h1122_3344, 32'd0, 1'b0, 2);
        check("t1_we_cycles", we_cnt - we0, 32'd1);
        check("t1_we_addr", {22'd0, we_addr}, 32'd4);
        check("t1_mem4", mem[4], 32'h1122_3344);
        txn("t1_lw", 1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 32'h1122_3344, 1'b0, 2);

        // 2: byte store by read-modify-write
        we0 = we_cnt;
        txn("t2_sb", 1'b1, 2'b00, 1'b0, 32'h012, 32'h0000_00AB, 32'd0, 1'b0, 3);
        check("t2_we_cycles", we_cnt - we0, 32'd1);
        check("t2_we_din", we_din, 32'h11AB_3344);
        check("t2_mem4", mem[4], 32'h11AB_3344);
        txn("t2_sh", 1'b1, 2'b01, 1'b0, 32'h016, 32'h1234_BEEF, 32'd0, 1'b0, 3);
        check("t2_mem5", mem[5], 32'hBEEF_0000);

        // 3: lane selection and extension
        txn("t3_sw", 1'b1, 2'b10, 1'b0, 32'h020, 32'h80FF_7F01, 32'd0, 1'b0, 2);
        txn("t3_lb0", 1'b0, 2'b00, 1'b0, 32'h020, 32'd0, 32'h0000_0001, 1'b0, 2);
        txn("t3_lb1", 1'b0, 2'b00, 1'b0, 32'h021, 32'd0, 32'h0000_007F, 1'b0, 2);
        txn("t3_lb2", 1'b0, 2'b00, 1'b0, 32'h022, 32'd0, 32'hFFFF_FFFF, 1'b0, 2);
        txn("t3_lb3", 1'b0, 2'b00, 1'b0, 32'h023, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
        txn("t3_lbu2", 1'b0, 2'b00, 1'b1, 32'h022, 32'd0, 32'h0000_00FF, 1'b0, 2);
        txn("t3_lh2", 1'b0, 2'b01, 1'b0, 32'h022, 32'd0, 32'hFFFF_80FF, 1'b0, 2);
        txn("t3_lhu2", 1'b0, 2'b01, 1'b1, 32'h022, 32'd0, 32'h0000_80FF, 1'b0, 2);
        txn("t3_lh0", 1'b0, 2'b01, 1'b0, 32'h020, 32'd0, 32'h0000_7F01, 1'b0, 2);
        txn("t3_lw_wrap", 1'b0, 2'b10, 1'b0, 32'h0000_1020, 32'd0, 32'h80FF_7F01, 1'b0, 2);
        txn("t3_lrsvd", 1'b0, 2'b11, 1'b0, 32'h020, 32'd0, 32'h80FF_7F01, 1'b0, 2);

        // 4: misaligned word load
        we0 = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        txn("t4_lw_mis", 1'b0, 2'b10, 1'b0, 32'h012, 32'd0, 32'd0, 1'b1, 1);
`else
        txn("t4_lw_mis", 1'b0, 2'b10, 1'b0, 32'h012, 32'd0, 32'h11AB_3344, 1'b0, 2);
`endif
        check("t4_no_write", we_cnt - we0, 32'd0);

        // 5: response back-pressure
        rsp_ready = 1'b0;
        do_req("t5_lw_hold", 1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 32'h11AB_3344, 1'b0, 2);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("t5_valid_held", {31'd0, rsp_valid}, 32'd1);
            check("t5_rdata_held", rsp_rdata, 32'h11AB_3344);
            check("t5_req_ready_low", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done("t5_lw_hold");
        txn("t5_resume", 1'b0, 2'b00, 1'b1, 32'h017, 32'd0, 32'h0000_00BE, 1'b0, 2);

        // 6: reset in the middle of the write cycle
        do_req("t6_sb_rst", 1'b1, 2'b00, 1'b0, 32'h020, 32'h0000_0055, 32'd0, 1'b0, 3);
        n = 0;
        while (!dm_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_wr", {31'd0, dm_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_we_drop", {31'd0, dm_we}, 32'd0);
        exp_q.delete();
        name_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_req_ready", {31'd0, req_ready}, 32'd1);
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_mem8", mem[8], 32'h80FF_7F01);
        txn("t6_lw_after", 1'b0, 2'b10, 1'b0, 32'h020, 32'd0, 32'h80FF_7F01, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
